event_stretcher: RTL and testbench

Multi-channel, parametrised pulse stretcher and event tracker for short asynchronous-domain event strobes, such as the PS/2 mouse new-event strobe, before slower consumers sample them.
- Each channel turns a trigger (level or rising edge) into an output held high for a runtime-programmable number of cycles.
- Retrigger behaviour is configurable.
- Each channel emits a one-cycle end-of-stretch strobe.
- The block records which channel fired most recently, replacing the ad-hoc single-channel 3-bit stretcher and the left/right "last button" latch in the display top level.

---
 rtl/event_stretcher_pkg.sv | 8 +
 rtl/event_stretcher_stretch_channel.sv | 35 +++
 rtl/event_stretcher.sv | 53 +++++
 tb/tb_event_stretcher.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/event_stretcher_pkg.sv
// event_stretcher_pkg: trigger-mode encodings and id-width helper shared by the stretcher slice.
package event_stretcher_pkg;
    localparam int TRIG_LEVEL = 0;
    localparam int TRIG_RISE  = 1;
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/event_stretcher_stretch_channel.sv
// stretch_channel: one channel's trigger detection, reloadable down-counter and end-of-stretch strobe.
module stretch_channel
    import event_stretcher_pkg::*;
#(
    parameter int LEN_W     = 4,
    parameter int EDGE_MODE = TRIG_LEVEL,
    parameter int RETRIGGER = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] len,
    input  logic             in,
    output logic             acc,
    output logic             out,
    output logic             end_pulse
);
    logic             in_d;
    logic [LEN_W-1:0] cnt;
    logic             trig;
    assign trig = (EDGE_MODE == TRIG_RISE) ? (in & ~in_d) : in;
    // cnt<=1 still admits a trigger so a held level reloads seamlessly at expiry
    assign acc  = trig & ((RETRIGGER != 0) || (cnt <= LEN_W'(1)));
    assign out  = (cnt != '0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_d      <= 1'b0;
            cnt       <= '0;
            end_pulse <= 1'b0;
        end else begin
            in_d      <= in;
            cnt       <= acc ? ((len == '0) ? LEN_W'(1) : len) : ((cnt != '0) ? cnt - LEN_W'(1) : cnt);
            end_pulse <= (cnt == LEN_W'(1)) & ~acc;
        end
    end
endmodule

// File: rtl/event_stretcher.sv
// event_stretcher: multi-channel pulse stretcher that also records the lowest-index channel
// of the most recent accepted trigger.
module event_stretcher
    import event_stretcher_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int LEN_W     = 4,
    parameter int EDGE_MODE = TRIG_LEVEL,
    parameter int RETRIGGER = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LEN_W-1:0]              len,
    input  logic [CHANNELS-1:0]           in,
    output logic [CHANNELS-1:0]           out,
    output logic [CHANNELS-1:0]           end_pulse,
    output logic [id_width(CHANNELS)-1:0] last_id,
    output logic                          last_valid
);
    localparam int ID_W = id_width(CHANNELS);
    logic [CHANNELS-1:0] acc;
    logic [ID_W-1:0]     sel;
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        stretch_channel #(
            .LEN_W(LEN_W),
            .EDGE_MODE(EDGE_MODE),
            .RETRIGGER(RETRIGGER)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .len(len),
            .in(in[g]),
            .acc(acc[g]),
            .out(out[g]),
            .end_pulse(end_pulse[g])
        );
    end
    // scanning downward lets the lowest accepting index win
    always_comb begin
        sel = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (acc[i]) sel = ID_W'(i);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_id    <= '0;
            last_valid <= 1'b0;
        end else if (acc != '0) begin
            last_id    <= sel;
            last_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_event_stretcher.sv
// tb_event_stretcher: directed checks of three stretcher configurations sharing one stimulus.
module tb_event_stretcher;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] len = '0;
    logic [3:0] in  = '0;
    logic [3:0] out, end_pulse, out_nr, end_nr, out_e, end_e;
    logic [1:0] last_id, last_id_nr, last_id_e;
    logic       last_valid, last_valid_nr, last_valid_e;
    int         vec = 0;
    int         err = 0;

    always #5 clk = ~clk;

    event_stretcher #(.CHANNELS(4), .LEN_W(4), .EDGE_MODE(0), .RETRIGGER(1)) dut (
        .clk(clk), .rst(rst), .len(len), .in(in), .out(out), .end_pulse(end_pulse),
        .last_id(last_id), .last_valid(last_valid));
    event_stretcher #(.CHANNELS(4), .LEN_W(4), .EDGE_MODE(0), .RETRIGGER(0)) dut_nr (
        .clk(clk), .rst(rst), .len(len), .in(in), .out(out_nr), .end_pulse(end_nr),
        .last_id(last_id_nr), .last_valid(last_valid_nr));
    event_stretcher #(.CHANNELS(4), .LEN_W(4), .EDGE_MODE(1), .RETRIGGER(1)) dut_e (
        .clk(clk), .rst(rst), .len(len), .in(in), .out(out_e), .end_pulse(end_e),
        .last_id(last_id_e), .last_valid(last_valid_e));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in = '0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        #3;
        vec++;
        if ({out, end_pulse, last_id, last_valid} !== 11'b0) begin
            err++;
            $display("FAIL reset_hold: out=%b end=%b id=%0d valid=%b, want all zero", out, end_pulse, last_id, last_valid);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            vec++;
            if ({out, end_pulse, last_id, last_valid} !== 11'b0) begin
                err++;
                $display("FAIL reset_idle[%0d]: out=%b end=%b id=%0d valid=%b, want all zero", k, out, end_pulse, last_id, last_valid);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [7:0] eo = 8'b0001_1111;
        logic [7:0] ee = 8'b0010_0000;
        logic [7:0] no = 8'b0000_0111;
        logic [7:0] ne = 8'b0000_1000;
        len = 4'd3;
        for (int k = 0; k < 8; k++) begin
            in = (k == 0 || k == 2) ? 4'b0001 : 4'b0000;
            tick();
            vec++;
            if (out[0] !== eo[k] || end_pulse[0] !== ee[k]) begin
                err++;
                $display("FAIL retrig[%0d]: out=%b end=%b, want out=%b end=%b", k, out[0], end_pulse[0], eo[k], ee[k]);
            end
            vec++;
            if (out_nr[0] !== no[k] || end_nr[0] !== ne[k]) begin
                err++;
                $display("FAIL noretrig[%0d]: out=%b end=%b, want out=%b end=%b", k, out_nr[0], end_nr[0], no[k], ne[k]);
            end
        end
        vec++;
        if (last_id !== 2'd0 || last_valid !== 1'b1) begin
            err++;
            $display("FAIL retrig_id: id=%0d valid=%b, want id=0 valid=1", last_id, last_valid);
        end
        idle();
    endtask

    task automatic test_expiry_reload();
        logic [7:0] no = 8'b0011_1111;
        logic [7:0] ne = 8'b0100_0000;
        len = 4'd3;
        for (int k = 0; k < 8; k++) begin
            in = (k == 0 || k == 2 || k == 3) ? 4'b0001 : 4'b0000;
            tick();
            vec++;
            if (out_nr[0] !== no[k] || end_nr[0] !== ne[k]) begin
                err++;
                $display("FAIL expiry_reload[%0d]: out=%b end=%b, want out=%b end=%b", k, out_nr[0], end_nr[0], no[k], ne[k]);
            end
        end
        idle();
    endtask

    task automatic test_held_level();
        logic [11:0] eo = 12'h1ff;
        logic [11:0] ee = 12'h200;
        logic [11:0] xo = 12'h003;
        logic [11:0] xe = 12'h004;
        len = 4'd2;
        for (int k = 0; k < 12; k++) begin
            in = (k < 8) ? 4'b0100 : 4'b0000;
            tick();
            vec++;
            if (out[2] !== eo[k] || end_pulse[2] !== ee[k]) begin
                err++;
                $display("FAIL held_level[%0d]: out=%b end=%b, want out=%b end=%b", k, out[2], end_pulse[2], eo[k], ee[k]);
            end
            vec++;
            if (out_e[2] !== xo[k] || end_e[2] !== xe[k]) begin
                err++;
                $display("FAIL held_edge[%0d]: out=%b end=%b, want out=%b end=%b", k, out_e[2], end_e[2], xo[k], xe[k]);
            end
        end
        idle();
    endtask

    task automatic test_priority();
        len = 4'd3;
        in = 4'b1010;
        tick();
        in = '0;
        vec++;
        if (last_id !== 2'd1 || last_valid !== 1'b1) begin
            err++;
            $display("FAIL prio_simul: id=%0d valid=%b, want id=1 valid=1", last_id, last_valid);
        end
        idle();
        in = 4'b1000;
        tick();
        in = '0;
        vec++;
        if (last_id !== 2'd3) begin
            err++;
            $display("FAIL prio_single: id=%0d, want 3", last_id);
        end
        idle();
        len = 4'd0;
        in = 4'b0001;
        tick();
        in = '0;
        vec++;
        if (out[0] !== 1'b1 || end_pulse[0] !== 1'b0 || last_id !== 2'd0) begin
            err++;
            $display("FAIL len0_a: out=%b end=%b id=%0d, want out=1 end=0 id=0", out[0], end_pulse[0], last_id);
        end
        tick();
        vec++;
        if (out[0] !== 1'b0 || end_pulse[0] !== 1'b1) begin
            err++;
            $display("FAIL len0_b: out=%b end=%b, want out=0 end=1", out[0], end_pulse[0]);
        end
        tick();
        vec++;
        if (end_pulse[0] !== 1'b0) begin
            err++;
            $display("FAIL len0_c: end=%b, want 0", end_pulse[0]);
        end
        idle();
    endtask

    task automatic test_mid_reset();
        len = 4'd5;
        in = 4'b0001;
        tick();
        in = '0;
        tick();
        tick();
        vec++;
        if (out[0] !== 1'b1) begin
            err++;
            $display("FAIL midrst_pre: out=%b, want 1", out[0]);
        end
        #2 rst = 1'b0;
        #1;
        vec++;
        if (out !== 4'b0 || end_pulse !== 4'b0 || last_valid !== 1'b0) begin
            err++;
            $display("FAIL midrst_async: out=%b end=%b valid=%b, want 0 0 0", out, end_pulse, last_valid);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vec++;
            if (out !== 4'b0 || end_pulse !== 4'b0 || last_valid !== 1'b0) begin
                err++;
                $display("FAIL midrst_post[%0d]: out=%b end=%b valid=%b, want 0 0 0", k, out, end_pulse, last_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_retrigger();
        test_expiry_reload();
        test_held_level();
        test_priority();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
